// File: rtl/ram_handshake_responder_pkg.sv
// Shared definitions for the MFA/MFC memory responder: SPARC op3 codes,
// FSM states, access sizes and the op3 decoder.
package ram_handshake_responder_pkg;

    localparam logic [5:0] LD   = 6'b000000;
    localparam logic [5:0] LDUB = 6'b000001;
    localparam logic [5:0] LDUH = 6'b000010;
    localparam logic [5:0] ST   = 6'b000100;
    localparam logic [5:0] STB  = 6'b000101;
    localparam logic [5:0] STH  = 6'b000110;
    localparam logic [5:0] LDSB = 6'b001001;
    localparam logic [5:0] LDSH = 6'b001010;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE} size_e;

    typedef struct packed {
        size_e size;
        logic  is_store;
        logic  sign_ext;
    } op_info_t;

    // SZ_NONE marks an illegal op3
    function automatic op_info_t decode_op(input logic [5:0] mop);
        op_info_t info;
        info = '{size: SZ_NONE, is_store: 1'b0, sign_ext: 1'b0};
        case (mop)
            LD:      info = '{size: SZ_WORD, is_store: 1'b0, sign_ext: 1'b0};
            LDUB:    info = '{size: SZ_BYTE, is_store: 1'b0, sign_ext: 1'b0};
            LDUH:    info = '{size: SZ_HALF, is_store: 1'b0, sign_ext: 1'b0};
            ST:      info = '{size: SZ_WORD, is_store: 1'b1, sign_ext: 1'b0};
            STB:     info = '{size: SZ_BYTE, is_store: 1'b1, sign_ext: 1'b0};
            STH:     info = '{size: SZ_HALF, is_store: 1'b1, sign_ext: 1'b0};
            LDSB:    info = '{size: SZ_BYTE, is_store: 1'b0, sign_ext: 1'b1};
            LDSH:    info = '{size: SZ_HALF, is_store: 1'b0, sign_ext: 1'b1};
            default: info = '{size: SZ_NONE, is_store: 1'b0, sign_ext: 1'b0};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/ram_handshake_responder_if.sv
// MFA/MFC request/response bundle between the datapath (master) and the
// memory responder (slave).
interface ram_handshake_responder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              MFA;
    logic [5:0]        MOP;
    logic [ADDR_W-1:0] Address;
    logic [31:0]       DataIn;
    logic [31:0]       DataOut;
    logic              MFC;
    logic              ERR;

    modport master (
        output MFA, MOP, Address, DataIn,
        input  DataOut, MFC, ERR
    );

    modport slave (
        input  MFA, MOP, Address, DataIn,
        output DataOut, MFC, ERR
    );
endinterface

// File: rtl/ram_handshake_responder_mem_byte_array.sv
// Byte-wide storage, 2**ADDR_W deep. Four consecutive bytes (wrapping) are
// read big-endian from addr; we[i] writes byte addr+i from wdata lane i.
module mem_byte_array #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        we,
    output logic [31:0]       rdata
);
    logic [7:0] mem [2**ADDR_W];

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rdata[8*(3-i) +: 8] = mem[addr + ADDR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr + ADDR_W'(i)] <= wdata[8*(3-i) +: 8];
            end
        end
    end
endmodule

// File: rtl/ram_handshake_responder.sv
// MFA/MFC memory responder: SPARC byte/half/word loads and stores after
// WAIT_CYCLES wait states. Define MEM_ALIGN_CHECK_EN to reject misaligned accesses.
module ram_handshake_responder
    import ram_handshake_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic                      Clk,
    input logic                      Clr,
    ram_handshake_responder_if.slave bus
);
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [5:0]        mop_q, mop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic [31:0]       dout_q, dout_d;
    logic              mfc_q, mfc_d;
    logic              err_q, err_d;

    op_info_t          info;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_err;
    logic [31:0]       rd;
    logic [31:0]       ld_val;
    logic [3:0]        st_we;
    logic [31:0]       st_wdata;
    logic              access_now;
    logic [3:0]        mem_we;

    // Access decode works on the request captured at accept
    always_comb begin
        info     = decode_op(mop_q);
        acc_addr = addr_q;
        acc_err  = (info.size == SZ_NONE);
`ifdef MEM_ALIGN_CHECK_EN
        if ((info.size == SZ_HALF && addr_q[0]) ||
            (info.size == SZ_WORD && addr_q[1:0] != 2'b00)) begin
            acc_err = 1'b1;
        end
`else
        if (info.size == SZ_HALF) begin
            acc_addr[0] = 1'b0;
        end else if (info.size == SZ_WORD) begin
            acc_addr[1:0] = 2'b00;
        end
`endif
    end

    // Lane steering: the addressed byte always sits in the top lane of rd
    always_comb begin
        ld_val   = '0;
        st_we    = '0;
        st_wdata = '0;
        case (info.size)
            SZ_BYTE: begin
                ld_val   = info.sign_ext ? {{24{rd[31]}}, rd[31:24]} : {24'd0, rd[31:24]};
                st_we    = 4'b0001;
                st_wdata = {din_q[7:0], 24'd0};
            end
            SZ_HALF: begin
                ld_val   = info.sign_ext ? {{16{rd[31]}}, rd[31:16]} : {16'd0, rd[31:16]};
                st_we    = 4'b0011;
                st_wdata = {din_q[15:0], 16'd0};
            end
            SZ_WORD: begin
                ld_val   = rd;
                st_we    = 4'b1111;
                st_wdata = din_q;
            end
            default: begin
                ld_val   = '0;
                st_we    = '0;
                st_wdata = '0;
            end
        endcase
    end

    assign access_now = (state_q == BUSY) && bus.MFA && (cnt_q == 4'd0);
    assign mem_we     = (access_now && !acc_err && info.is_store) ? st_we : 4'b0000;

    mem_byte_array #(.ADDR_W(ADDR_W)) u_mem (
        .clk   (Clk),
        .addr  (acc_addr),
        .wdata (st_wdata),
        .we    (mem_we),
        .rdata (rd)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mop_d   = mop_q;
        addr_d  = addr_q;
        din_d   = din_q;
        dout_d  = dout_q;
        mfc_d   = mfc_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.MFA) begin
                    mop_d   = bus.MOP;
                    addr_d  = bus.Address;
                    din_d   = bus.DataIn;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!bus.MFA) begin
                    state_d = IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mfc_d   = 1'b1;
                    err_d   = acc_err;
                    dout_d  = (acc_err || info.is_store) ? 32'd0 : ld_val;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.MFA) begin
                    mfc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mop_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            dout_q  <= '0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mop_q   <= mop_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            dout_q  <= dout_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
        end
    end

    assign bus.DataOut = dout_q;
    assign bus.MFC     = mfc_q;
    assign bus.ERR     = err_q;
endmodule

// File: tb/tb_ram_handshake_responder.sv
// Directed and randomized checks of ram_handshake_responder against a
// byte-array reference model of the SPARC load/store rules.
module tb_ram_handshake_responder;
    localparam int unsigned AW   = 8;
    localparam int unsigned WAIT = 2;

    logic Clk = 1'b0;
    logic Clr;
    always #5 Clk = ~Clk;

    ram_handshake_responder_if #(.ADDR_W(AW)) bus_if ();

    ram_handshake_responder #(.ADDR_W(AW), .WAIT_CYCLES(WAIT)) dut (
        .Clk (Clk),
        .Clr (Clr),
        .bus (bus_if.slave)
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;
    byte unsigned model_mem [256];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: big-endian byte memory, sizes/extension from the op3 table
    function automatic void ref_access(input logic [5:0] mop, input int a_in, input logic [31:0] din,
                                       output logic [31:0] dout, output logic err);
        int  size;
        int  a;
        bit  store;
        bit  signd;
        longint v;
        a     = a_in;
        store = 0;
        signd = 0;
        case (mop)
            6'b000000: size = 4;
            6'b000001: size = 1;
            6'b000010: size = 2;
            6'b000100: begin size = 4; store = 1; end
            6'b000101: begin size = 1; store = 1; end
            6'b000110: begin size = 2; store = 1; end
            6'b001001: begin size = 1; signd = 1; end
            6'b001010: begin size = 2; signd = 1; end
            default:   size = 0;
        endcase
        dout = 32'd0;
        err  = 1'b0;
        if (size == 0) begin
            err = 1'b1;
            return;
        end
        if (a % size != 0) begin
`ifdef MEM_ALIGN_CHECK_EN
            err = 1'b1;
            return;
`else
            a = a - (a % size);
`endif
        end
        if (store) begin
            for (int i = 0; i < size; i++) begin
                model_mem[(a + i) % 256] = byte'((din >> (8 * (size - 1 - i))) & 32'hFF);
            end
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v = v * 256 + longint'(model_mem[(a + i) % 256]);
            if (signd && v >= (longint'(1) << (8 * size - 1))) v = v - (longint'(1) << (8 * size));
            dout = v[31:0];
        end
    endfunction

    task automatic do_txn(input logic [5:0] mop, input logic [7:0] a, input logic [31:0] din,
                          input int hold, input string tag,
                          output logic [31:0] got, output logic got_err);
        logic [31:0] exp_d;
        logic        exp_e;
        int          n;
        bus_if.MFA     = 1'b1;
        bus_if.MOP     = mop;
        bus_if.Address = a;
        bus_if.DataIn  = din;
        @(posedge Clk); #1;
        // inputs after accept must be ignored
        bus_if.MOP     = 6'($urandom);
        bus_if.Address = 8'($urandom);
        bus_if.DataIn  = $urandom;
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (bus_if.MFC !== 1'b1 && n < 40);
        ref_access(mop, int'(a), din, exp_d, exp_e);
        got     = bus_if.DataOut;
        got_err = bus_if.ERR;
        check({tag, " latency"}, 32'(n), 32'(WAIT + 1));
        check({tag, " data"}, got, exp_d);
        check({tag, " err"}, 32'(got_err), 32'(exp_e));
        for (int h = 0; h < hold; h++) begin
            @(posedge Clk); #1;
            check({tag, " hold mfc"}, 32'(bus_if.MFC), 32'd1);
            check({tag, " hold data"}, bus_if.DataOut, exp_d);
        end
        bus_if.MFA = 1'b0;
        @(posedge Clk); #1;
        check({tag, " release mfc"}, 32'(bus_if.MFC), 32'd0);
        check({tag, " release err"}, 32'(bus_if.ERR), 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        logic        gerr;
        logic [5:0]  ops [8];
        logic [5:0]  mop;
        int          r;
        ops = '{6'b000000, 6'b000001, 6'b000010, 6'b000100,
                6'b000101, 6'b000110, 6'b001001, 6'b001010};

        Clr            = 1'b0;
        bus_if.MFA     = 1'b0;
        bus_if.MOP     = '0;
        bus_if.Address = '0;
        bus_if.DataIn  = '0;
        #1;
        check("reset mfc", 32'(bus_if.MFC), 32'd0);
        check("reset err", 32'(bus_if.ERR), 32'd0);
        check("reset data", bus_if.DataOut, 32'd0);
        repeat (2) @(posedge Clk);
        #1 Clr = 1'b1;

        for (int i = 0; i < 64; i++) do_txn(6'b000100, 8'(4 * i), $urandom, 0, "fill", got, gerr);

        // 1: word store/load
        do_txn(6'b000100, 8'h10, 32'hDEADBEEF, 0, "t1 st", got, gerr);
        do_txn(6'b000000, 8'h10, 32'h0, 1, "t1 ld", got, gerr);
        check("t1 ld const", got, 32'hDEADBEEF);
        // 2: sub-word loads and extension
        do_txn(6'b000001, 8'h13, 32'h0, 0, "t2 ldub", got, gerr);
        check("t2 ldub const", got, 32'h000000EF);
        do_txn(6'b001001, 8'h10, 32'h0, 0, "t2 ldsb", got, gerr);
        check("t2 ldsb const", got, 32'hFFFFFFDE);
        do_txn(6'b001010, 8'h12, 32'h0, 0, "t2 ldsh", got, gerr);
        check("t2 ldsh const", got, 32'hFFFFBEEF);
        do_txn(6'b000010, 8'h10, 32'h0, 0, "t2 lduh", got, gerr);
        check("t2 lduh const", got, 32'h0000DEAD);
        // 3: byte store touches one byte only
        do_txn(6'b000101, 8'h11, 32'h12345677, 0, "t3 stb", got, gerr);
        do_txn(6'b000000, 8'h10, 32'h0, 0, "t3 ld", got, gerr);
        check("t3 ld const", got, 32'hDE77BEEF);

        // 4: abort during BUSY
        bus_if.MFA = 1'b1; bus_if.MOP = 6'b000100; bus_if.Address = 8'h20; bus_if.DataIn = 32'h11111111;
        @(posedge Clk); #1;
        bus_if.MFA = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clk); #1;
            check("t4 abort mfc", 32'(bus_if.MFC), 32'd0);
        end
        do_txn(6'b000000, 8'h20, 32'h0, 0, "t4 ld", got, gerr);

        // 5: misaligned word
        do_txn(6'b000000, 8'h21, 32'h0, 0, "t5 ld21", got, gerr);

        // 6: illegal op held in DONE, then reset during DONE
        do_txn(6'b000111, 8'h40, 32'hCAFEF00D, 5, "t6 ill", got, gerr);
        check("t6 ill err", 32'(gerr), 32'd1);
        check("t6 ill data", got, 32'd0);
        do_txn(6'b000000, 8'h40, 32'h0, 0, "t6 ld", got, gerr);

        bus_if.MFA = 1'b1; bus_if.MOP = 6'b000000; bus_if.Address = 8'h40;
        for (int i = 0; i < WAIT + 2; i++) @(posedge Clk);
        #1 check("t6 pre mfc", 32'(bus_if.MFC), 32'd1);
        #2 Clr = 1'b0;
        #1;
        check("t6 clr mfc", 32'(bus_if.MFC), 32'd0);
        check("t6 clr data", bus_if.DataOut, 32'd0);
        bus_if.MFA = 1'b0;
        @(posedge Clk); #1 Clr = 1'b1;

        // reset during BUSY discards the store
        bus_if.MFA = 1'b1; bus_if.MOP = 6'b000100; bus_if.Address = 8'h30; bus_if.DataIn = 32'h55AA55AA;
        @(posedge Clk); #2 Clr = 1'b0;
        bus_if.MFA = 1'b0;
        @(posedge Clk); #1 Clr = 1'b1;
        @(posedge Clk); #1;
        do_txn(6'b000000, 8'h30, 32'h0, 0, "busy clr ld", got, gerr);

        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            mop = (r < 8) ? ops[r] : 6'($urandom);
            do_txn(mop, 8'($urandom), $urandom, $urandom_range(0, 2),
                   $sformatf("rnd%0d op%02h", k, mop), got, gerr);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
